// File: rtl/data_mem_responder_if.sv
// Load/store port between the CPU execute stage and the data-memory responder.
// The CPU side is the master; the responder is the slave.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one request at a time, byte/half/word
// loads and stores on a word-organised RAM, optional fixed wait latency.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  data_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg, we_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        load_ok_reg, load_ok_next;
  logic        commit;

  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [3:0]  byte_en;
  logic [31:0] wr_lane;
  logic [ADDR_WIDTH-1:0] cur_idx;

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] rd_word_reg;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // With LATENCY=0 the commit happens on the accept edge, so the live request
  // must feed the datapath; otherwise the latched copy does.
  assign cur_we     = (state_reg == IDLE) ? bus.req_we     : we_reg;
  assign cur_funct3 = (state_reg == IDLE) ? bus.req_funct3 : funct3_reg;
  assign cur_addr   = (state_reg == IDLE) ? bus.req_addr   : addr_reg;
  assign cur_wdata  = (state_reg == IDLE) ? bus.req_wdata  : wdata_reg;
  assign cur_idx    = cur_addr[ADDR_WIDTH+1:2];

  assign cur_err = (cur_funct3 == 3'd3) || (cur_funct3 == 3'd6) || (cur_funct3 == 3'd7)
                || (cur_we && (cur_funct3 > 3'd2))
                || ((cur_funct3[1:0] == 2'd1) && cur_addr[0])
                || ((cur_funct3 == 3'd2) && (cur_addr[1:0] != 2'd0))
                || ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign byte_en[gi] = (cur_funct3[1:0] == 2'd0) ? (cur_addr[1:0] == LANE) :
                         (cur_funct3[1:0] == 2'd1) ? (cur_addr[1] == LANE[1]) : 1'b1;
    assign wr_lane[8*gi +: 8] = (cur_funct3[1:0] == 2'd0) ? cur_wdata[7:0] :
                                (cur_funct3[1:0] == 2'd1) ? cur_wdata[8*(gi%2) +: 8] :
                                                            cur_wdata[8*gi +: 8];
  end

  always_ff @(posedge CLK) begin
    if (commit && RSTN) begin
      rd_word_reg <= mem[cur_idx];
      if (cur_we && !cur_err) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[cur_idx][8*i +: 8] <= wr_lane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      load_ok_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      funct3_reg    <= funct3_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      load_ok_reg   <= load_ok_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    we_next        = we_reg;
    funct3_next    = funct3_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_err_next   = rsp_err_reg;
    load_ok_next   = load_ok_reg;
    commit         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          we_next     = bus.req_we;
          funct3_next = bus.req_funct3;
          addr_next   = bus.req_addr;
          wdata_next  = bus.req_wdata;
          if (LATENCY == 0) begin
            commit = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) commit = 1'b1;
        else                 cnt_next = cnt_reg - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          rsp_err_next   = 1'b0;
          load_ok_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (commit) begin
      state_next     = RESP;
      rsp_valid_next = 1'b1;
      rsp_err_next   = cur_err;
      load_ok_next   = !cur_we && !cur_err;
    end
  end

  // Lane selection and extension run on the registered RAM word, so the
  // response stays stable for as long as RESP is held.
  always_comb begin
    case (addr_reg[1:0])
      2'd0:    rd_byte = rd_word_reg[7:0];
      2'd1:    rd_byte = rd_word_reg[15:8];
      2'd2:    rd_byte = rd_word_reg[23:16];
      default: rd_byte = rd_word_reg[31:24];
    endcase
    rd_half = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    case (funct3_reg)
      3'd0:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
      3'd4:    rd_ext = {24'd0, rd_byte};
      3'd5:    rd_ext = {16'd0, rd_half};
      default: rd_ext = rd_word_reg;
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = load_ok_reg ? rd_ext : 32'd0;

endmodule
